// File: rtl/drp_pkg.sv
// Shared definitions for the DRP reconfiguration controller: register map,
// field positions, reset values, reserved-bit masks and FSM state type.
package drp_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned N_REGS     = 23;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned CNT_W      = 2;

    // DRP addresses
    localparam logic [ADDR_W-1:0] ADDR_CH5_R1  = 7'h06;
    localparam logic [ADDR_W-1:0] ADDR_CH5_R2  = 7'h07;
    localparam logic [ADDR_W-1:0] ADDR_CH0_R1  = 7'h08;
    localparam logic [ADDR_W-1:0] ADDR_CH4_R2  = 7'h11;
    localparam logic [ADDR_W-1:0] ADDR_CH6_R1  = 7'h12;
    localparam logic [ADDR_W-1:0] ADDR_CH6_R2  = 7'h13;
    localparam logic [ADDR_W-1:0] ADDR_FB_R1   = 7'h14;
    localparam logic [ADDR_W-1:0] ADDR_FB_R2   = 7'h15;
    localparam logic [ADDR_W-1:0] ADDR_DIV     = 7'h16;
    localparam logic [ADDR_W-1:0] ADDR_LOCK_LO = 7'h18;
    localparam logic [ADDR_W-1:0] ADDR_LOCK_HI = 7'h1A;
    localparam logic [ADDR_W-1:0] ADDR_POWER   = 7'h28;
    localparam logic [ADDR_W-1:0] ADDR_FILT1   = 7'h4E;
    localparam logic [ADDR_W-1:0] ADDR_FILT2   = 7'h4F;

    // Storage indices: channel i at 2i/2i+1, then FB, Div, Lock x3, Power, Filt x2
    localparam int unsigned IDX_FB_R1  = 14;
    localparam int unsigned IDX_FB_R2  = 15;
    localparam int unsigned IDX_DIV    = 16;
    localparam int unsigned IDX_LOCK   = 17;
    localparam int unsigned IDX_POWER  = 20;
    localparam int unsigned IDX_FILT1  = 21;
    localparam int unsigned IDX_FILT2  = 22;

    // Field bit positions
    localparam int unsigned R1_PMUX_LSB     = 13;
    localparam int unsigned R1_HIGH_LSB     = 6;
    localparam int unsigned R1_LOW_LSB      = 0;
    localparam int unsigned R2_EDGE_BIT     = 7;
    localparam int unsigned R2_NOCOUNT_BIT  = 6;
    localparam int unsigned R2_DELAY_LSB    = 0;
    localparam int unsigned DIV_NOCOUNT_BIT = 12;

    // Register reset values
    localparam logic [DATA_W-1:0] RST_CLKREG1 = 16'h0041;
    localparam logic [DATA_W-1:0] RST_CLKREG2 = 16'h0000;
    localparam logic [DATA_W-1:0] RST_DIV     = 16'h1041;
    localparam logic [DATA_W-1:0] RST_POWER   = 16'h1111;
    localparam logic [DATA_W-1:0] RST_MISC    = 16'h0000;

    // Decoded output reset values
    localparam logic [7:0] RST_DIVIDE = 8'd2;
    localparam logic [6:0] RST_HIGH   = 7'd1;
    localparam logic [7:0] RST_MULT   = 8'd2;
    localparam logic [7:0] RST_DIVCLK = 8'd1;

    // Reserved-bit masks
    localparam logic [DATA_W-1:0] RSV_CLKREG1 = 16'h1000;
    localparam logic [DATA_W-1:0] RSV_CLKREG2 = 16'hFC00;
    localparam logic [DATA_W-1:0] RSV_DIV     = 16'hC000;
    localparam logic [DATA_W-1:0] RSV_NONE    = 16'h0000;

    typedef enum logic {S_IDLE, S_WAIT} drp_state_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } reg_sel_t;

    // 6-bit count field where 0 encodes 64
    function automatic logic [6:0] count_val(input logic [5:0] f);
        return (f == 6'd0) ? 7'd64 : {1'b0, f};
    endfunction

    // High + low count of a ClkReg1-style register
    function automatic logic [7:0] count_sum(input logic [DATA_W-1:0] r1);
        return 8'(count_val(r1[R1_HIGH_LSB +: 6])) + 8'(count_val(r1[R1_LOW_LSB +: 6]));
    endfunction

    // Map a DRP address to a storage index; channels >= n_clkout are unmapped
    function automatic reg_sel_t addr_decode(input logic [ADDR_W-1:0] addr,
                                             input int unsigned      n_clkout);
        reg_sel_t    sel;
        int unsigned ch;
        logic        is_ch;
        sel   = '0;
        ch    = 0;
        is_ch = 1'b0;
        if (addr == ADDR_CH5_R1 || addr == ADDR_CH5_R2) begin
            ch    = 5;
            is_ch = 1'b1;
        end else if (addr >= ADDR_CH0_R1 && addr <= ADDR_CH4_R2) begin
            ch    = 32'(addr[ADDR_W-1:1]) - 32'd4;
            is_ch = 1'b1;
        end else if (addr == ADDR_CH6_R1 || addr == ADDR_CH6_R2) begin
            ch    = 6;
            is_ch = 1'b1;
        end
        if (is_ch) begin
            if (ch < n_clkout) begin
                sel.hit = 1'b1;
                sel.idx = IDX_W'(2 * ch) | IDX_W'(addr[0]);
            end
        end else if (addr == ADDR_FB_R1) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_FB_R1);
        end else if (addr == ADDR_FB_R2) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_FB_R2);
        end else if (addr == ADDR_DIV) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_DIV);
        end else if (addr >= ADDR_LOCK_LO && addr <= ADDR_LOCK_HI) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_LOCK) + IDX_W'(addr - ADDR_LOCK_LO);
        end else if (addr == ADDR_POWER) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_POWER);
        end else if (addr == ADDR_FILT1) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_FILT1);
        end else if (addr == ADDR_FILT2) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(IDX_FILT2);
        end
        return sel;
    endfunction

    // Reset value by storage index
    function automatic logic [DATA_W-1:0] reg_reset(input int unsigned idx);
        logic [DATA_W-1:0] val;
        if (idx <= IDX_FB_R2)       val = (idx % 2 == 1) ? RST_CLKREG2 : RST_CLKREG1;
        else if (idx == IDX_DIV)    val = RST_DIV;
        else if (idx == IDX_POWER)  val = RST_POWER;
        else                        val = RST_MISC;
        return val;
    endfunction

    // Reserved-bit mask by storage index
    function automatic logic [DATA_W-1:0] reg_rsv_mask(input int unsigned idx);
        logic [DATA_W-1:0] val;
        if (idx <= IDX_FB_R2)       val = (idx % 2 == 1) ? RSV_CLKREG2 : RSV_CLKREG1;
        else if (idx == IDX_DIV)    val = RSV_DIV;
        else                        val = RSV_NONE;
        return val;
    endfunction

endpackage

// File: rtl/drp_clkreg_decode.sv
// Decodes one ClkReg1/ClkReg2 pair into divide, high time, edge, delay and
// phase-mux fields. Purely combinational.
module drp_clkreg_decode
    import drp_pkg::*;
(
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic [7:0]        divide_c,
    output logic [6:0]        high_c,
    output logic              edge_c,
    output logic [5:0]        delay_c,
    output logic [2:0]        pmux_c
);

    logic unused_bits;
    assign unused_bits = ^{reg1[12], reg2[15:8]};

    // Count fields, overridden when the counter is bypassed (no-count)
    always_comb begin
        divide_c = count_sum(reg1);
        high_c   = count_val(reg1[R1_HIGH_LSB +: 6]);
        edge_c   = reg2[R2_EDGE_BIT];
        if (reg2[R2_NOCOUNT_BIT]) begin
            divide_c = 8'd1;
            high_c   = 7'd1;
            edge_c   = 1'b0;
        end
    end

    assign delay_c = reg2[R2_DELAY_LSB +: 6];
    assign pmux_c  = reg1[R1_PMUX_LSB +: 3];

endmodule

// File: rtl/drp_reconf_ctrl.sv
// DRP register bank and clock-config decoder. Accepts one DRP transaction at
// a time (back-to-back allowed in the DRDY cycle), answers after RD_LATENCY
// cycles and republishes decoded clock settings on every mapped write.
// Optional: DRP_RESERVED_CHECK_EN protects reserved bits and flags writes
// that try to change them.
module drp_reconf_ctrl
    import drp_pkg::*;
#(
    parameter int unsigned N_CLKOUT   = 7,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    DCLK,
    input  logic                    RST,
    input  logic [6:0]              DADDR,
    input  logic                    DEN,
    input  logic                    DWE,
    input  logic [15:0]             DI,
    output logic [15:0]             DO,
    output logic                    DRDY,
    output logic [8*N_CLKOUT-1:0]   CLKOUT_DIVIDE,
    output logic [7*N_CLKOUT-1:0]   CLKOUT_HIGH,
    output logic [N_CLKOUT-1:0]     CLKOUT_EDGE,
    output logic [6*N_CLKOUT-1:0]   CLKOUT_DELAY,
    output logic [3*N_CLKOUT-1:0]   CLKOUT_PMUX,
    output logic [7:0]              CLKFBOUT_MULT,
    output logic [7:0]              DIVCLK_DIVIDE,
    output logic                    CFG_UPDATE,
    output logic                    DRP_ERR
);

    drp_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs   [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];

    reg_sel_t          sel;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_err;
    logic              accept;
    logic              busy_den;
    logic              wr_en;
    logic [DATA_W-1:0] acc_data;
    logic              acc_err;
    logic              acc_upd;
    logic [DATA_W-1:0] pend_data;
    logic              pend_err;
    logic              pend_upd;
    logic              fire;
    logic [DATA_W-1:0] fire_data;
    logic              fire_err;
    logic              fire_upd;

    logic [N_CLKOUT-1:0][7:0] ch_divide_c;
    logic [N_CLKOUT-1:0][6:0] ch_high_c;
    logic [N_CLKOUT-1:0]      ch_edge_c;
    logic [N_CLKOUT-1:0][5:0] ch_delay_c;
    logic [N_CLKOUT-1:0][2:0] ch_pmux_c;
    logic [7:0]               fb_mult_c;
    logic [6:0]               fb_unused_high;
    logic                     fb_unused_edge;
    logic [5:0]               fb_unused_delay;
    logic [2:0]               fb_unused_pmux;
    logic [7:0]               divclk_c;

    assign sel      = addr_decode(DADDR, N_CLKOUT);
    assign accept   = DEN && (state == S_IDLE || DRDY);
    assign busy_den = DEN && (state == S_WAIT) && !DRDY;
    assign wr_en    = accept && DWE && sel.hit;
    assign acc_data = (!DWE && sel.hit) ? old_val : '0;
    assign acc_err  = !sel.hit || (DWE && rsv_err);
    assign acc_upd  = DWE && sel.hit;

    // Completion happens on the accept edge itself when latency is one
    assign fire      = (RD_LATENCY == 1) ? accept   : (state == S_WAIT && !DRDY && cnt == CNT_W'(1));
    assign fire_data = (RD_LATENCY == 1) ? acc_data : pend_data;
    assign fire_err  = (RD_LATENCY == 1) ? acc_err  : pend_err;
    assign fire_upd  = (RD_LATENCY == 1) ? acc_upd  : pend_upd;

    // Write data merge and reserved-bit check
    always_comb begin
        old_val = regs[sel.idx];
`ifdef DRP_RESERVED_CHECK_EN
        wr_data = (DI & ~reg_rsv_mask(32'(sel.idx))) | (old_val & reg_rsv_mask(32'(sel.idx)));
        rsv_err = |((DI ^ old_val) & reg_rsv_mask(32'(sel.idx)));
`else
        wr_data = DI;
        rsv_err = 1'b0;
`endif
    end

    // Register file as it will be after this edge; decoders look ahead so a
    // single-cycle write is reflected in the same DRDY cycle
    always_comb begin
        regs_d = regs;
        if (wr_en) regs_d[sel.idx] = wr_data;
    end

    for (genvar i = 0; i < N_CLKOUT; i++) begin : g_ch
        drp_clkreg_decode u_dec (
            .reg1     (regs_d[2*i]),
            .reg2     (regs_d[2*i+1]),
            .divide_c (ch_divide_c[i]),
            .high_c   (ch_high_c[i]),
            .edge_c   (ch_edge_c[i]),
            .delay_c  (ch_delay_c[i]),
            .pmux_c   (ch_pmux_c[i])
        );
    end

    drp_clkreg_decode u_fb_dec (
        .reg1     (regs_d[IDX_FB_R1]),
        .reg2     (regs_d[IDX_FB_R2]),
        .divide_c (fb_mult_c),
        .high_c   (fb_unused_high),
        .edge_c   (fb_unused_edge),
        .delay_c  (fb_unused_delay),
        .pmux_c   (fb_unused_pmux)
    );

    assign divclk_c = regs_d[IDX_DIV][DIV_NOCOUNT_BIT] ? 8'd1 : count_sum(regs_d[IDX_DIV]);

    // Register storage
    always_ff @(posedge DCLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < N_REGS; k++) regs[k] <= reg_reset(k);
        end else begin
            regs <= regs_d;
        end
    end

    // Transaction FSM with registered DRDY/DO/DRP_ERR/CFG_UPDATE
    always_ff @(posedge DCLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_data  <= '0;
            pend_err   <= 1'b0;
            pend_upd   <= 1'b0;
            DRDY       <= 1'b0;
            DO         <= '0;
            DRP_ERR    <= 1'b0;
            CFG_UPDATE <= 1'b0;
        end else begin
            DRDY       <= fire;
            DO         <= fire ? fire_data : '0;
            DRP_ERR    <= (fire && fire_err) || busy_den;
            CFG_UPDATE <= fire && fire_upd;
            if (accept) begin
                state     <= S_WAIT;
                cnt       <= CNT_W'(RD_LATENCY - 1);
                pend_data <= acc_data;
                pend_err  <= acc_err;
                pend_upd  <= acc_upd;
            end else if (state == S_WAIT) begin
                if (DRDY) state <= S_IDLE;
                else      cnt   <= cnt - CNT_W'(1);
            end
        end
    end

    // Decoded clock settings, republished only when a mapped write completes
    always_ff @(posedge DCLK) begin
        if (RST) begin
            CLKOUT_DIVIDE <= {N_CLKOUT{RST_DIVIDE}};
            CLKOUT_HIGH   <= {N_CLKOUT{RST_HIGH}};
            CLKOUT_EDGE   <= '0;
            CLKOUT_DELAY  <= '0;
            CLKOUT_PMUX   <= '0;
            CLKFBOUT_MULT <= RST_MULT;
            DIVCLK_DIVIDE <= RST_DIVCLK;
        end else if (fire && fire_upd) begin
            CLKOUT_DIVIDE <= ch_divide_c;
            CLKOUT_HIGH   <= ch_high_c;
            CLKOUT_EDGE   <= ch_edge_c;
            CLKOUT_DELAY  <= ch_delay_c;
            CLKOUT_PMUX   <= ch_pmux_c;
            CLKFBOUT_MULT <= fb_mult_c;
            DIVCLK_DIVIDE <= divclk_c;
        end
    end

endmodule

// File: tb/tb_drp_reconf_ctrl.sv
// Directed bench: dut_a uses defaults (7 channels, latency 1), dut_b uses
// 4 channels and latency 3.
module tb_drp_reconf_ctrl;

    localparam int unsigned NA = 7;
    localparam int unsigned LA = 1;
    localparam int unsigned NB = 4;
    localparam int unsigned LB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic             a_rst, a_den, a_dwe;
    logic [6:0]       a_daddr;
    logic [15:0]      a_di, a_do;
    logic             a_drdy, a_cfg, a_err;
    logic [8*NA-1:0]  a_div;
    logic [7*NA-1:0]  a_high;
    logic [NA-1:0]    a_edge;
    logic [6*NA-1:0]  a_delay;
    logic [3*NA-1:0]  a_pmux;
    logic [7:0]       a_mult, a_divclk;

    logic             b_rst, b_den, b_dwe;
    logic [6:0]       b_daddr;
    logic [15:0]      b_di, b_do;
    logic             b_drdy, b_cfg, b_err;
    logic [8*NB-1:0]  b_div;
    logic [7*NB-1:0]  b_high;
    logic [NB-1:0]    b_edge;
    logic [6*NB-1:0]  b_delay;
    logic [3*NB-1:0]  b_pmux;
    logic [7:0]       b_mult, b_divclk;

    drp_reconf_ctrl #(.N_CLKOUT(NA), .RD_LATENCY(LA)) dut_a (
        .DCLK(clk), .RST(a_rst), .DADDR(a_daddr), .DEN(a_den), .DWE(a_dwe), .DI(a_di),
        .DO(a_do), .DRDY(a_drdy), .CLKOUT_DIVIDE(a_div), .CLKOUT_HIGH(a_high),
        .CLKOUT_EDGE(a_edge), .CLKOUT_DELAY(a_delay), .CLKOUT_PMUX(a_pmux),
        .CLKFBOUT_MULT(a_mult), .DIVCLK_DIVIDE(a_divclk), .CFG_UPDATE(a_cfg), .DRP_ERR(a_err)
    );

    drp_reconf_ctrl #(.N_CLKOUT(NB), .RD_LATENCY(LB)) dut_b (
        .DCLK(clk), .RST(b_rst), .DADDR(b_daddr), .DEN(b_den), .DWE(b_dwe), .DI(b_di),
        .DO(b_do), .DRDY(b_drdy), .CLKOUT_DIVIDE(b_div), .CLKOUT_HIGH(b_high),
        .CLKOUT_EDGE(b_edge), .CLKOUT_DELAY(b_delay), .CLKOUT_PMUX(b_pmux),
        .CLKFBOUT_MULT(b_mult), .DIVCLK_DIVIDE(b_divclk), .CFG_UPDATE(b_cfg), .DRP_ERR(b_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic we, input logic [6:0] addr, input logic [15:0] di);
        a_den = 1'b1; a_dwe = we; a_daddr = addr; a_di = di;
    endtask

    task automatic a_idle();
        a_den = 1'b0; a_dwe = 1'b0; a_daddr = '0; a_di = '0;
    endtask

    task automatic b_req(input logic we, input logic [6:0] addr, input logic [15:0] di);
        b_den = 1'b1; b_dwe = we; b_daddr = addr; b_di = di;
    endtask

    task automatic b_idle();
        b_den = 1'b0; b_dwe = 1'b0; b_daddr = '0; b_di = '0;
    endtask

    task automatic a_resp(input string tag, input logic [15:0] d, input logic rdy,
                          input logic cfg, input logic err);
        check({tag, ".DO"}, a_do, d);
        check({tag, ".DRDY"}, a_drdy, rdy);
        check({tag, ".CFG"}, a_cfg, cfg);
        check({tag, ".ERR"}, a_err, err);
    endtask

    task automatic b_resp(input string tag, input logic [15:0] d, input logic rdy,
                          input logic cfg, input logic err);
        check({tag, ".DO"}, b_do, d);
        check({tag, ".DRDY"}, b_drdy, rdy);
        check({tag, ".CFG"}, b_cfg, cfg);
        check({tag, ".ERR"}, b_err, err);
    endtask

    initial begin
        // Reset with DEN held high: must be ignored
        a_rst = 1'b1; b_rst = 1'b1;
        a_req(1'b0, 7'h08, 16'h0); b_req(1'b0, 7'h08, 16'h0);
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0; a_idle(); b_idle();
        a_resp("a_rst", 16'h0, 1'b0, 1'b0, 1'b0);
        check("a_rst.DIVIDE", a_div, 56'h02020202020202);
        check("a_rst.HIGH", a_high, {7{7'd1}});
        check("a_rst.EDGE", a_edge, 7'h0);
        check("a_rst.DELAY", a_delay, 42'h0);
        check("a_rst.PMUX", a_pmux, 21'h0);
        check("a_rst.MULT", a_mult, 8'd2);
        check("a_rst.DIVCLK", a_divclk, 8'd1);
        check("b_rst.DIVIDE", b_div, 32'h02020202);
        step();
        check("a_rst_den.DRDY", a_drdy, 1'b0);

        // Read ClkReg1 ch0 after reset
        a_req(1'b0, 7'h08, 16'h0);
        step(); a_idle();
        a_resp("a_rd08", 16'h0041, 1'b1, 1'b0, 1'b0);
        check("a_rd08.DIV0", a_div[7:0], 8'd2);
        step();
        a_resp("a_rd08_end", 16'h0, 1'b0, 1'b0, 1'b0);

        // Write 0x08=0x0103, back-to-back 0x09=0x0080
        a_req(1'b1, 7'h08, 16'h0103);
        step();
        a_resp("a_wr08", 16'h0, 1'b1, 1'b1, 1'b0);
        check("a_wr08.DIV0", a_div[7:0], 8'd7);
        check("a_wr08.HIGH0", a_high[6:0], 7'd4);
        check("a_wr08.EDGE0", a_edge[0], 1'b0);
        a_req(1'b1, 7'h09, 16'h0080);
        step(); a_idle();
        a_resp("a_wr09", 16'h0, 1'b1, 1'b1, 1'b0);
        check("a_wr09.EDGE0", a_edge[0], 1'b1);
        check("a_wr09.DIV0", a_div[7:0], 8'd7);
        check("a_wr09.DIV1", a_div[15:8], 8'd2);
        step();
        a_resp("a_wr09_end", 16'h0, 1'b0, 1'b0, 1'b0);

        // Zero count fields mean 64; then no-count forces divide 1
        a_req(1'b1, 7'h08, 16'h0000);
        step();
        check("a_wr08z.DIV0", a_div[7:0], 8'd128);
        check("a_wr08z.HIGH0", a_high[6:0], 7'd64);
        a_req(1'b1, 7'h09, 16'h0040);
        step(); a_idle();
        check("a_nocnt.DIV0", a_div[7:0], 8'd1);
        check("a_nocnt.HIGH0", a_high[6:0], 7'd1);
        check("a_nocnt.EDGE0", a_edge[0], 1'b0);
        check("a_nocnt.CFG", a_cfg, 1'b1);
        step();

        // Read back ClkReg2 ch0
        a_req(1'b0, 7'h09, 16'h0);
        step(); a_idle();
        a_resp("a_rd09", 16'h0040, 1'b1, 1'b0, 1'b0);
        step();

        // Unmapped write and read
        a_req(1'b1, 7'h05, 16'h1234);
        step(); a_idle();
        a_resp("a_wr05", 16'h0, 1'b1, 1'b0, 1'b1);
        step();
        check("a_wr05_end.ERR", a_err, 1'b0);
        a_req(1'b0, 7'h7F, 16'h0);
        step(); a_idle();
        a_resp("a_rd7f", 16'h0, 1'b1, 1'b0, 1'b1);
        step();

        // Feedback multiply and input divider
        a_req(1'b1, 7'h14, 16'h0145);
        step();
        check("a_fb.MULT", a_mult, 8'd10);
        check("a_fb.CFG", a_cfg, 1'b1);
        a_req(1'b1, 7'h16, 16'h0082);
        step(); a_idle();
        check("a_div.DIVCLK", a_divclk, 8'd4);
        check("a_div.MULT", a_mult, 8'd10);
        step();

        // Channel 6 lives at 0x12/0x13
        a_req(1'b1, 7'h12, 16'h6083);
        step();
        check("a_ch6.DIV6", a_div[55:48], 8'd5);
        check("a_ch6.HIGH6", a_high[48:42], 7'd2);
        check("a_ch6.PMUX6", a_pmux[20:18], 3'd3);
        a_req(1'b1, 7'h13, 16'h0025);
        step(); a_idle();
        check("a_ch6.DELAY6", a_delay[41:36], 6'h25);
        check("a_ch6.EDGE6", a_edge[6], 1'b0);
        step();

        // Lock register write/read and Power reset value
        a_req(1'b1, 7'h18, 16'hABCD);
        step();
        a_resp("a_wr18", 16'h0, 1'b1, 1'b1, 1'b0);
        a_req(1'b0, 7'h18, 16'h0);
        step();
        a_resp("a_rd18", 16'hABCD, 1'b1, 1'b0, 1'b0);
        a_req(1'b0, 7'h28, 16'h0);
        step(); a_idle();
        a_resp("a_rd28", 16'h1111, 1'b1, 1'b0, 1'b0);
        step();

        // B: channel 5 unmapped with 4 channels, latency 3
        b_req(1'b1, 7'h06, 16'h1234);
        step(); b_idle();
        check("b_wr06_t1.DRDY", b_drdy, 1'b0);
        step();
        check("b_wr06_t2.DRDY", b_drdy, 1'b0);
        step();
        b_resp("b_wr06_t3", 16'h0, 1'b1, 1'b0, 1'b1);
        step();
        b_resp("b_wr06_t4", 16'h0, 1'b0, 1'b0, 1'b0);
        b_req(1'b0, 7'h06, 16'h0);
        step(); b_idle();
        step(); step();
        b_resp("b_rd06", 16'h0, 1'b1, 1'b0, 1'b1);
        step();

        // B: DEN while busy
        b_req(1'b0, 7'h08, 16'h0);
        step();
        b_resp("b_busy_t1", 16'h0, 1'b0, 1'b0, 1'b0);
        b_req(1'b0, 7'h0A, 16'h0);
        step(); b_idle();
        b_resp("b_busy_t2", 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        b_resp("b_busy_t3", 16'h0041, 1'b1, 1'b0, 1'b0);
        step();
        b_resp("b_busy_t4", 16'h0, 1'b0, 1'b0, 1'b0);

        // B: decoded outputs change only in the DRDY cycle
        b_req(1'b1, 7'h08, 16'h0103);
        step(); b_idle();
        step();
        check("b_wr08_t2.DIV0", b_div[7:0], 8'd2);
        check("b_wr08_t2.CFG", b_cfg, 1'b0);
        step();
        b_resp("b_wr08_t3", 16'h0, 1'b1, 1'b1, 1'b0);
        check("b_wr08_t3.DIV0", b_div[7:0], 8'd7);
        step();

        // B: reset at t+2 aborts the transaction
        b_req(1'b0, 7'h08, 16'h0);
        step(); b_idle();
        step();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        b_resp("b_abort_t3", 16'h0, 1'b0, 1'b0, 1'b0);
        check("b_abort_t3.DIV0", b_div[7:0], 8'd2);
        step();
        check("b_abort_t4.DRDY", b_drdy, 1'b0);
        step();
        check("b_abort_t5.DRDY", b_drdy, 1'b0);
        b_req(1'b0, 7'h08, 16'h0);
        step(); b_idle();
        step(); step();
        b_resp("b_rd08_after_rst", 16'h0041, 1'b1, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
